// File: rtl/pdp8l_iot_sequencer.sv
// PDP-8/L IOT sequencer: detects 6xxx IOT opcodes and emits the
// iopstart / IOP1 / IOP2 / IOP4 / iopdone timing with ARM-programmable slots.
module pdp8l_iot_sequencer (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CSTEP,
  input  logic        armwrite,
  input  logic        armraddr,
  input  logic        armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        iotreq,
  input  logic [11:0] mbin,
  output logic        iopstart,
  output logic [11:0] ioopcode,
  output logic        iop1,
  output logic        iop2,
  output logic        iop4,
  output logic        iobusy,
  output logic        iopdone
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1P  = 3'd1,
    S1G  = 3'd2,
    S2P  = 3'd3,
    S2G  = 3'd4,
    S4P  = 3'd5,
    S4G  = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [13:0] wid_q, wid_d;
  logic [13:0] gap_q, gap_d;
  logic        en_q, en_d;
  logic        ovr_q, ovr_d;
  logic        prev_q, prev_d;
  logic [11:0] opc_q, opc_d;
  logic        start_q, start_d;
  logic        p1_q, p1_d;
  logic        p2_q, p2_d;
  logic        p4_q, p4_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic wr1;
  logic trig;
  logic unused_wdata;

  assign wr1  = armwrite & armwaddr;
  assign trig = CSTEP & iotreq & ~prev_q
              & (mbin[11:9] == 3'o6) & en_q;
  assign unused_wdata = ^armwdata[30:28];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wid_q   <= 14'd99;
      gap_q   <= 14'd99;
      en_q    <= 1'b1;
      ovr_q   <= 1'b0;
      prev_q  <= 1'b0;
      opc_q   <= '0;
      start_q <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      p4_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      ovr_q   <= ovr_d;
      prev_q  <= prev_d;
      opc_q   <= opc_d;
      start_q <= start_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p4_q    <= p4_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // one down-counter, reloaded with width or gap on every slot entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr1) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (CSTEP) begin
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            state_d = S1P;
            cnt_d   = wid_q;
          end
        end
        DONE: state_d = IDLE;
        default: begin
          if (cnt_q != 14'd0) begin
            cnt_d = cnt_q - 14'd1;
          end else begin
            state_d = state_t'(state_q + 3'd1);
            cnt_d   = state_d[0] ? wid_q : gap_q;
          end
        end
      endcase
    end
  end

  always_comb begin
    wid_d   = wid_q;
    gap_d   = gap_q;
    en_d    = en_q;
    ovr_d   = ovr_q;
    prev_d  = prev_q;
    opc_d   = opc_q;
    start_d = start_q;
    if (wr1) begin
      en_d    = armwdata[31];
      gap_d   = armwdata[27:14];
      wid_d   = armwdata[13:0];
      ovr_d   = 1'b0;
      start_d = 1'b0;
    end else if (CSTEP) begin
      prev_d  = iotreq;
      start_d = trig & (state_q == IDLE);
      if (trig && state_q == IDLE)
        opc_d = mbin;
      if (trig && state_q != IDLE)
        ovr_d = 1'b1;
    end
    p1_d   = (state_d == S1P) & opc_d[0];
    p2_d   = (state_d == S2P) & opc_d[1];
    p4_d   = (state_d == S4P) & opc_d[2];
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign armrdata = armraddr
    ? {en_q, 1'b0, ovr_q, busy_q, gap_q, wid_q}
    : 32'h4953_0001;

  assign iopstart = start_q;
  assign ioopcode = opc_q;
  assign iop1     = p1_q;
  assign iop2     = p2_q;
  assign iop4     = p4_q;
  assign iobusy   = busy_q;
  assign iopdone  = done_q;

endmodule

// File: tb/tb_pdp8l_iot_sequencer.sv
// Scoreboard bench for pdp8l_iot_sequencer: stimulus queues expected
// output edges, a monitor pops and compares them as the DUT produces them.
module tb_pdp8l_iot_sequencer;

  logic        CLOCK;
  logic        RESET;
  logic        CSTEP;
  logic        armwrite;
  logic        armraddr;
  logic        armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        iotreq;
  logic [11:0] mbin;
  logic        iopstart;
  logic [11:0] ioopcode;
  logic        iop1;
  logic        iop2;
  logic        iop4;
  logic        iobusy;
  logic        iopdone;

  pdp8l_iot_sequencer dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .CSTEP    (CSTEP),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .iotreq   (iotreq),
    .mbin     (mbin),
    .iopstart (iopstart),
    .ioopcode (ioopcode),
    .iop1     (iop1),
    .iop2     (iop2),
    .iop4     (iop4),
    .iobusy   (iobusy),
    .iopdone  (iopdone)
  );

  typedef struct {
    int          k;
    int          c;
    logic [11:0] o;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  cdiv = 1;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 0;

  initial begin
    CLOCK = 0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(posedge CLOCK) cyc <= cyc + 1;

  initial begin
    CSTEP = 0;
    forever begin
      @(negedge CLOCK);
      CSTEP = ((cyc + 1) % cdiv == 0);
    end
  end

  function automatic string nm(int k);
    case (k)
      0: return "START";
      1: return "IOP1_RISE";
      2: return "IOP1_FALL";
      3: return "IOP2_RISE";
      4: return "IOP2_FALL";
      5: return "IOP4_RISE";
      6: return "IOP4_FALL";
      7: return "DONE";
      default: return "IDLE";
    endcase
  endfunction

  task automatic push(int k, int c, logic [11:0] o);
    ev_t e;
    e.k = k;
    e.c = c;
    e.o = o;
    q.push_back(e);
  endtask

  // expected edges of a complete sequence triggered at edge p
  task automatic push_seq(int p, logic [11:0] o, int w, int g);
    int t;
    t = p;
    push(0, t, o);
    for (int i = 0; i < 3; i++) begin
      if (o[i]) push(1 + 2 * i, t, o);
      t += (w + 1) * cdiv;
      if (o[i]) push(2 + 2 * i, t, o);
      t += (g + 1) * cdiv;
    end
    push(7, t, o);
    push(8, t + cdiv, o);
  endtask

  task automatic got(int k);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s at cycle %0d opc %o",
               nm(k), cyc, ioopcode);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.c != cyc || e.o !== ioopcode) begin
        errors++;
        $display("FAIL event got %s@%0d opc %o required %s@%0d opc %o",
                 nm(k), cyc, ioopcode, nm(e.k), e.c, e.o);
      end
    end
  endtask

  initial begin
    logic ps, p1, p2, p4, pb, pd;
    wait (mon_en);
    @(negedge CLOCK);
    ps = iopstart; p1 = iop1; p2 = iop2;
    p4 = iop4; pb = iobusy; pd = iopdone;
    forever begin
      @(negedge CLOCK);
      if (iopstart && !ps) got(0);
      if (iop1 && !p1) got(1);
      if (!iop1 && p1) got(2);
      if (iop2 && !p2) got(3);
      if (!iop2 && p2) got(4);
      if (iop4 && !p4) got(5);
      if (!iop4 && p4) got(6);
      if (iopdone && !pd) got(7);
      if (!iobusy && pb) got(8);
      ps = iopstart; p1 = iop1; p2 = iop2;
      p4 = iop4; pb = iobusy; pd = iopdone;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic rd(bit a, logic [31:0] exp, string name);
    @(negedge CLOCK);
    armraddr = a;
    #1 chk(name, armrdata, exp);
  endtask

  task automatic wr(bit a, logic [31:0] d);
    @(negedge CLOCK);
    armwrite = 1;
    armwaddr = a;
    armwdata = d;
    @(negedge CLOCK);
    armwrite = 0;
    armwaddr = 0;
  endtask

  task automatic trig(logic [11:0] m, bit exp_seq, int w, int g,
                      output int p);
    @(negedge CLOCK);
    while ((cyc + 1) % cdiv != 0) @(negedge CLOCK);
    iotreq = 1;
    mbin = m;
    p = cyc + 1;
    if (exp_seq) push_seq(p, m, w, g);
  endtask

  task automatic drop(int n);
    repeat (n) @(negedge CLOCK);
    iotreq = 0;
    repeat (2 * cdiv + 1) @(negedge CLOCK);
  endtask

  task automatic wait_edge(int e);
    while (cyc + 1 < e) @(negedge CLOCK);
  endtask

  task automatic wait_empty(int budget, string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending %0d next %s@%0d",
               name, q.size(), nm(q[0].k), q[0].c);
      q.delete();
    end
    repeat (3) @(negedge CLOCK);
  endtask

  initial begin
    int p;
    RESET = 1; armwrite = 0; armraddr = 0; armwaddr = 0;
    armwdata = 0; iotreq = 0; mbin = 0;
    repeat (3) @(negedge CLOCK);
    RESET = 0;
    mon_en = 1;
    chk("rst_outs",
        {13'd0, iopstart, iop1, iop2, iop4, iobusy, iopdone, ioopcode},
        32'd0);
    rd(0, 32'h4953_0001, "reg0");
    rd(1, 32'h8018_C063, "reg1_rst");
    wr(0, 32'h0000_0000);
    rd(1, 32'h8018_C063, "reg1_w0_ignored");

    wr(1, 32'h8000_C002);
    rd(1, 32'h8000_C002, "reg1_w2g3");
    trig(12'o6007, 1, 2, 3, p);
    drop(3);
    wait_empty(60, "seq_6007");
    chk("opc_hold", {20'd0, ioopcode}, 32'o6007);

    trig(12'o6002, 1, 2, 3, p);
    drop(3);
    wait_empty(60, "seq_6002");

    trig(12'o5002, 0, 2, 3, p);
    drop(3);
    repeat (25) @(negedge CLOCK);
    chk("non_iot_busy", {31'd0, iobusy}, 32'd0);

    wr(1, 32'h0000_C002);
    trig(12'o6007, 0, 2, 3, p);
    drop(3);
    repeat (25) @(negedge CLOCK);
    chk("disabled_busy", {31'd0, iobusy}, 32'd0);
    rd(1, 32'h0000_C002, "reg1_disabled");

    wr(1, 32'h8000_C002);
    trig(12'o6007, 1, 2, 3, p);
    wait_edge(p + 2);
    iotreq = 0;
    wait_edge(p + 11);
    iotreq = 1;
    wait_edge(p + 13);
    iotreq = 0;
    wait_empty(60, "seq_overrun");
    rd(1, 32'hA000_C002, "reg1_overrun");

    trig(12'o6007, 0, 2, 3, p);
    push(0, p, 12'o6007);
    push(1, p, 12'o6007);
    push(2, p + 3, 12'o6007);
    wait_edge(p + 5);
    armwrite = 1;
    armwaddr = 1;
    armwdata = 32'h8000_C002;
    push(8, p + 5, 12'o6007);
    @(negedge CLOCK);
    armwrite = 0;
    armwaddr = 0;
    chk("abort_busy", {31'd0, iobusy}, 32'd0);
    drop(3);
    repeat (25) @(negedge CLOCK);
    wait_empty(10, "seq_abort");
    rd(1, 32'h8000_C002, "reg1_ovr_clr");

    wr(1, 32'h8000_0000);
    trig(12'o6005, 1, 0, 0, p);
    drop(3);
    wait_empty(30, "seq_w0g0");

    cdiv = 4;
    repeat (2) @(negedge CLOCK);
    wr(1, 32'h8000_C002);
    trig(12'o6007, 1, 2, 3, p);
    drop(8);
    wait_empty(200, "seq_div4");

    trig(12'o6001, 0, 2, 3, p);
    push(0, p, 12'o6001);
    push(1, p, 12'o6001);
    wait_edge(p + 4);
    RESET = 1;
    iotreq = 0;
    push(2, p + 4, 12'o0000);
    push(8, p + 4, 12'o0000);
    @(negedge CLOCK);
    RESET = 0;
    chk("rst_mid_iop1", {31'd0, iop1}, 32'd0);
    chk("rst_mid_busy", {31'd0, iobusy}, 32'd0);
    wait_empty(10, "seq_reset");
    rd(1, 32'h8018_C063, "reg1_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
